// File: rtl/sdram_arbiter.sv
// Arbitrates ROM-download writes and CPU accesses onto a single byte-wide SDRAM
// controller port, with bounded-latency download bursts and command timeout.
module sdram_arbiter #(
    parameter int unsigned TIMEOUT  = 63,
    parameter int unsigned DL_BURST = 4
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic        dl_req,
    input  logic [14:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_ack,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_sel,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,

    output logic [22:0] sdram_addr,
    output logic [7:0]  sdram_din,
    output logic        sdram_rd,
    output logic        sdram_we,
    input  logic [7:0]  sdram_dout,
    input  logic        sdram_ready,

    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned ADDR_W   = 23;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned WCNT_W   = 6;
    localparam int unsigned STREAK_W = 3;

    localparam logic [1:0] SEL_RAM   = 2'b00;
    localparam logic [1:0] SEL_ROM_A = 2'b01;
    localparam logic [1:0] SEL_ROM_B = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q,      state_d;
    logic [STREAK_W-1:0]   dl_streak_q,  dl_streak_d;
    logic [WCNT_W-1:0]     wait_cnt_q,   wait_cnt_d;
    logic                  owner_cpu_q,  owner_cpu_d;
    logic                  is_read_q,    is_read_d;
    logic [ADDR_W-1:0]     addr_q,       addr_d;
    logic [DATA_W-1:0]     din_q,        din_d;
    logic                  rd_q,         rd_d;
    logic                  we_q,         we_d;
    logic [DATA_W-1:0]     cpu_dout_q,   cpu_dout_d;
    logic                  cpu_ack_q,    cpu_ack_d;
    logic                  dl_ack_q,     dl_ack_d;
    logic                  busy_q,       busy_d;
    logic                  tmo_err_q,    tmo_err_d;

    logic                  grant_cpu_c;
    logic                  grant_dl_c;
    logic                  streak_full_c;
    logic                  ready_ok_c;
    logic                  expired_c;

    // Download wins unless it has already starved a waiting CPU for DL_BURST grants.
    always_comb begin
        streak_full_c = (dl_streak_q >= STREAK_W'(DL_BURST));
        grant_cpu_c   = cpu_req && (!dl_req || streak_full_c);
        grant_dl_c    = dl_req && !grant_cpu_c;
        ready_ok_c    = sdram_ready && (wait_cnt_q != '0);
        expired_c     = (wait_cnt_q == WCNT_W'(TIMEOUT - 1));
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        dl_streak_d = dl_streak_q;
        wait_cnt_d  = '0;
        owner_cpu_d = owner_cpu_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rd_d        = rd_q;
        we_d        = we_q;
        cpu_dout_d  = cpu_dout_q;
        cpu_ack_d   = 1'b0;
        dl_ack_d    = 1'b0;
        tmo_err_d   = tmo_err_q;

        if (!cpu_req) begin
            dl_streak_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                rd_d = 1'b0;
                we_d = 1'b0;
                if (grant_dl_c) begin
                    if (cpu_req) begin
                        dl_streak_d = dl_streak_q + 1'b1;
                    end
                    owner_cpu_d = 1'b0;
                    is_read_d   = 1'b0;
                    addr_d      = {8'd0, dl_addr};
                    din_d       = dl_data;
                    we_d        = 1'b1;
                    state_d     = S_WAIT;
                end else if (grant_cpu_c) begin
                    dl_streak_d = '0;
                    owner_cpu_d = 1'b1;
                    is_read_d   = !cpu_we;
                    case (cpu_sel)
                        SEL_RAM: begin
                            addr_d  = {7'd1, cpu_addr};
                            din_d   = cpu_din;
                            rd_d    = !cpu_we;
                            we_d    = cpu_we;
                            state_d = S_WAIT;
                        end
                        SEL_ROM_A, SEL_ROM_B: begin
                            // ROM is read-only: writes complete without touching SDRAM.
                            if (cpu_we) begin
                                cpu_ack_d = 1'b1;
                                state_d   = S_DONE;
                            end else begin
                                addr_d  = {8'd0, (cpu_sel == SEL_ROM_B), cpu_addr[13:0]};
                                rd_d    = 1'b1;
                                state_d = S_WAIT;
                            end
                        end
                        default: begin
                            cpu_dout_d = 8'hFF;
                            cpu_ack_d  = 1'b1;
                            state_d    = S_DONE;
                        end
                    endcase
                end
            end

            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (ready_ok_c || expired_c) begin
                    rd_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_DONE;
                    if (owner_cpu_q) begin
                        cpu_ack_d = 1'b1;
                    end else begin
                        dl_ack_d = 1'b1;
                    end
                    if (owner_cpu_q && is_read_q) begin
                        cpu_dout_d = ready_ok_c ? sdram_dout : 8'hFF;
                    end
                    if (!ready_ok_c) begin
                        tmo_err_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                rd_d    = 1'b0;
                we_d    = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                rd_d    = 1'b0;
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State register; reset aborts any transaction in flight without an ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dl_streak_q <= '0;
            wait_cnt_q  <= '0;
            owner_cpu_q <= 1'b0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            cpu_dout_q  <= 8'hFF;
            cpu_ack_q   <= 1'b0;
            dl_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_streak_q <= dl_streak_d;
            wait_cnt_q  <= wait_cnt_d;
            owner_cpu_q <= owner_cpu_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_ack_q   <= cpu_ack_d;
            dl_ack_q    <= dl_ack_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign dl_ack      = dl_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_dout    = cpu_dout_q;
    assign sdram_addr  = addr_q;
    assign sdram_din   = din_q;
    assign sdram_rd    = rd_q;
    assign sdram_we    = we_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63: maximum WAIT cycles before a command is abandoned.
REQ-002 SHALL have parameter DL_BURST, default 4: consecutive download grants allowed while a CPU request waits.
REQ-003 SHALL have the port clk_sys, in, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have the port reset, in, 1: synchronous, active-high.
REQ-005 SHALL have the port dl_req, in, 1: ROM download write request (ioctl), held until dl_ack.
REQ-006 SHALL have the port dl_addr, in, 15: download byte address.
REQ-007 SHALL have the port dl_data, in, 8: download write data.
REQ-008 SHALL have the port dl_ack, out, 1: one-cycle completion pulse.
REQ-009 SHALL have the port cpu_req, in, 1: CPU access request, held until cpu_ack.
REQ-010 SHALL have the port cpu_we, in, 1: 1 = write, 0 = read.
REQ-011 SHALL have the port cpu_sel, in, 2: 00 RAM, 01 ROM A, 10 ROM B (diagnostic), 11 unmapped.
REQ-012 SHALL have the port cpu_addr, in, 16: CPU byte address.
REQ-013 SHALL have the port cpu_din, in, 8: CPU write data.
REQ-014 SHALL have the port cpu_dout, out, 8: registered read data, valid while cpu_ack is high and held until the next CPU completion.
REQ-015 SHALL have the port cpu_ack, out, 1: one-cycle completion pulse.
REQ-016 SHALL have the port sdram_addr, out, 23: SDRAM byte address.
REQ-017 SHALL have the port sdram_din, out, 8: SDRAM write data.
REQ-018 SHALL have the port sdram_rd, out, 1: read strobe (level).
REQ-019 SHALL have the port sdram_we, out, 1: write strobe (level).
REQ-020 SHALL have the port sdram_dout, in, 8: SDRAM read data.
REQ-021 SHALL have the port sdram_ready, in, 1: controller completion.
REQ-022 SHALL have the port busy, out, 1: high in any state other than IDLE.
REQ-023 SHALL have the port timeout_err, out, 1: sticky; set on any timeout.

Function
REQ-024 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-025 IDLE transitions:
- no request: stays IDLE;
- dl_req and/or cpu_req high: grants one requester, latches its address, data, direction and select, and enters WAIT.
REQ-026 Priority SHALL be download over CPU, except that the CPU SHALL win once dl_streak = DL_BURST with cpu_req high.
REQ-027 The 3-bit counter dl_streak SHALL:
- increment on a download grant while cpu_req is high;
- clear on a CPU grant or while cpu_req is low.
REQ-028 Address mapping SHALL be:
- download: {8'd0, dl_addr};
- RAM: {7'd1, cpu_addr};
- ROM A: {9'd0, cpu_addr[13:0]};
- ROM B: {9'd1, cpu_addr[13:0]}.
REQ-029 In WAIT, exactly one strobe SHALL be high: sdram_we for download and RAM writes, sdram_rd for reads; sdram_addr and sdram_din SHALL be stable.
REQ-030 sdram_ready SHALL be ignored in the first WAIT cycle, giving a minimum strobe width of 2 cycles.
REQ-031 When sdram_ready is sampled high in WAIT from the second cycle on:
- strobes drop;
- read data is captured into cpu_dout;
- the FSM enters DONE.
REQ-032 In DONE, the granted requester's ack SHALL be high for exactly 1 cycle and the FSM SHALL then return to IDLE; strobes are low.
REQ-033 Minimum latency from the grant edge to ack SHALL be 2 cycles; a new grant SHALL be possible on the cycle after DONE.
REQ-034 A CPU write with cpu_sel 01 or 10 (ROM) SHALL issue no SDRAM command: WAIT is skipped (IDLE -> DONE) and cpu_ack is pulsed.
REQ-035 cpu_sel 11 SHALL issue no SDRAM command: IDLE -> DONE, cpu_dout = 8'hFF, cpu_ack pulsed.
REQ-036 A 6-bit wait counter SHALL clear on WAIT entry.
REQ-037 If the wait counter reaches TIMEOUT without sdram_ready:
- strobes drop;
- cpu_dout = 8'hFF for reads;
- timeout_err sets;
- the FSM enters DONE and the ack is still pulsed.
REQ-038 Request inputs SHALL be sampled only at the grant; deasserting a request after the grant SHALL NOT cancel the transaction, and the ack SHALL still pulse.
REQ-039 With simultaneous dl_req and cpu_req, only one ack SHALL pulse per transaction; the loser waits in IDLE arbitration.

Reset
REQ-040 While reset is high at a clock edge:
- the FSM goes to IDLE;
- all strobes, acks, busy and timeout_err are 0;
- dl_streak and the wait counter are 0;
- cpu_dout = 8'hFF;
- sdram_addr and sdram_din = 0.
REQ-041 Reset asserted mid-transaction SHALL abort it on that edge with no ack pulse; the requester re-requests.
REQ-042 The first grant after reset release SHALL be possible on the first edge with reset low.

Verification
REQ-043 Read path: cpu_req read, sel 00, addr 16'h1234; sdram_ready high on the 3rd WAIT cycle with sdram_dout 8'hA5 -> sdram_rd high for 3 cycles at sdram_addr 23'h011234, cpu_ack 1 cycle, cpu_dout 8'hA5.
REQ-044 Download burst: dl_req held for 6 transfers, cpu_req high throughout, ready every 2nd WAIT cycle -> grant order D,D,D,D,C,D,D; CPU granted after exactly 4 download grants.
REQ-045 Timeout: RAM write with sdram_ready held low -> sdram_we drops after 63 WAIT cycles, cpu_ack pulses, timeout_err = 1 and remains 1 until reset.
REQ-046 ROM write and unmapped access:
- cpu_we = 1, sel 01: no strobe, cpu_ack 1 cycle after the grant edge;
- sel 11 read: cpu_dout 8'hFF, no strobe.
REQ-047 Reset mid-WAIT: reset for 1 cycle during a download write -> sdram_we 0 and busy 0 the next cycle, no dl_ack; dl_req still high is re-granted on the first edge after release.
